mmio_initiator: RTL and testbench

MMIO_INITIATOR -- requirements
Module: mmio_initiator

---
 rtl/mmio_pkg.sv | 31 +++
 rtl/mmio_decoder.sv | 39 +++
 rtl/mmio_initiator.sv | 139 +++++++++++++
 tb/tb_mmio_initiator.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO initiator: FSM states, slot ids,
// slot geometry and the latched-request record.
package mmio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SLOT_NONE = 2'd0,
        SLOT_GPIO = 2'd1,
        SLOT_AUX  = 2'd2
    } slot_t;

    localparam logic [31:0] GPIO_BASE_DEF = 32'h1001_0024;
    localparam logic [31:0] AUX_BASE_DEF  = 32'h1001_0030;
    // Slot sizes in bytes (2 and 4 words).
    localparam logic [31:0] GPIO_SPAN = 32'd8;
    localparam logic [31:0] AUX_SPAN  = 32'd16;

    // Request captured in IDLE and presented to the peripheral during ACCESS.
    typedef struct packed {
        logic        we;
        logic [31:0] wdata;
        logic [31:0] word_off;
        slot_t       slot;
    } acc_t;

endpackage

// File: rtl/mmio_decoder.sv
// Combinational address decode: byte address -> slot id, word offset, hit.
// Misaligned addresses never hit.
module mmio_decoder
    import mmio_pkg::*;
#(
    parameter logic [31:0] GPIO_BASE = GPIO_BASE_DEF,
    parameter logic [31:0] AUX_BASE  = AUX_BASE_DEF
) (
    input  logic [31:0] addr,
    output slot_t       slot,
    output logic [31:0] word_off,
    output logic        hit
);

    logic [31:0] gpio_d;
    logic [31:0] aux_d;
    logic        aligned;

    // Unsigned distance from each base; a single compare covers both bounds.
    assign gpio_d  = addr - GPIO_BASE;
    assign aux_d   = addr - AUX_BASE;
    assign aligned = (addr[1:0] == 2'b00);

    // Pick the slot and convert the byte offset to a word offset.
    always_comb begin
        slot     = SLOT_NONE;
        word_off = '0;
        if (aligned && (gpio_d < GPIO_SPAN)) begin
            slot     = SLOT_GPIO;
            word_off = {2'b00, gpio_d[31:2]};
        end else if (aligned && (aux_d < AUX_SPAN)) begin
            slot     = SLOT_AUX;
            word_off = {2'b00, aux_d[31:2]};
        end
    end

    assign hit = (slot != SLOT_NONE);

endmodule

// File: rtl/mmio_initiator.sv
// CPU-side MMIO initiator: decodes a single request into a GPIO (fixed wait)
// or AUX (ack handshake with timeout) access and returns a one-cycle
// completion pulse with data and error qualifier.
module mmio_initiator
    import mmio_pkg::*;
#(
    parameter logic [31:0] GPIO_BASE = GPIO_BASE_DEF,
    parameter logic [31:0] AUX_BASE  = AUX_BASE_DEF,
    parameter int unsigned GPIO_WAIT = 1,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        cpu_err,
    output logic [31:0] per_addr,
    output logic [31:0] per_wdata,
    output logic        per_we,
    output logic        per_sel_gpio,
    output logic        per_sel_aux,
    input  logic [31:0] per_rdata_gpio,
    input  logic [31:0] per_rdata_aux,
    input  logic        per_ack_aux
);

    // Counter value on the final GPIO cycle / final AUX cycle before timeout.
    localparam logic [7:0] GPIO_LAST = GPIO_WAIT[7:0];
    localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    acc_t        acc_q;
    logic [7:0]  cnt_q;
    logic [31:0] rdata_q;
    logic        err_q;

    slot_t       dec_slot;
    logic [31:0] dec_off;
    logic        dec_hit;

    logic        resp_load;
    logic        resp_err;
    logic [31:0] resp_data;

    mmio_decoder #(
        .GPIO_BASE (GPIO_BASE),
        .AUX_BASE  (AUX_BASE)
    ) u_dec (
        .addr     (cpu_addr),
        .slot     (dec_slot),
        .word_off (dec_off),
        .hit      (dec_hit)
    );

    // State register; reset aborts any access without a completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state and the response to load on entry to RESP.
    always_comb begin
        state_d   = state_q;
        resp_load = 1'b0;
        resp_err  = 1'b0;
        resp_data = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    if (dec_hit) begin
                        state_d = ST_ACCESS;
                    end else begin
                        state_d   = ST_RESP;
                        resp_load = 1'b1;
                        resp_err  = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                if (acc_q.slot == SLOT_GPIO) begin
                    if (cnt_q == GPIO_LAST) begin
                        state_d   = ST_RESP;
                        resp_load = 1'b1;
                        resp_data = acc_q.we ? '0 : per_rdata_gpio;
                    end
                end else if (per_ack_aux) begin
                    // Ack beats a timeout expiring on the same cycle.
                    state_d   = ST_RESP;
                    resp_load = 1'b1;
                    resp_data = acc_q.we ? '0 : per_rdata_aux;
                end else if (cnt_q >= TO_LAST) begin
                    state_d   = ST_RESP;
                    resp_load = 1'b1;
                    resp_err  = 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request capture, saturating wait counter and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state_q == ST_IDLE) begin
                cnt_q <= '0;
                if (cpu_req) begin
                    acc_q <= '{we: cpu_we, wdata: cpu_wdata,
                               word_off: dec_off, slot: dec_slot};
                end
            end else if ((state_q == ST_ACCESS) && (cnt_q != 8'hFF)) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (resp_load) begin
                rdata_q <= resp_data;
                err_q   <= resp_err;
            end
        end
    end

    assign cpu_ready    = (state_q == ST_RESP);
    assign cpu_err      = cpu_ready & err_q;
    assign cpu_rdata    = rdata_q;
    assign per_addr     = acc_q.word_off;
    assign per_wdata    = acc_q.wdata;
    assign per_we       = acc_q.we;
    assign per_sel_gpio = (state_q == ST_ACCESS) && (acc_q.slot == SLOT_GPIO);
    assign per_sel_aux  = (state_q == ST_ACCESS) && (acc_q.slot == SLOT_AUX);

endmodule

// File: tb/tb_mmio_initiator.sv
// Bench for mmio_initiator: directed cases plus random transactions, each
// predicted from the address map and timing rules by a transaction-level model.
module tb_mmio_initiator;

    localparam logic [31:0] GB = 32'h1001_0024;
    localparam logic [31:0] AB = 32'h1001_0030;
    localparam int GW = 1;
    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_ready, cpu_err;
    logic [31:0] per_addr, per_wdata;
    logic        per_we, per_sel_gpio, per_sel_aux;
    logic [31:0] per_rdata_gpio, per_rdata_aux;
    logic        per_ack_aux;

    int nasrt = 0;
    int nfail = 0;

    mmio_initiator #(
        .GPIO_BASE (GB),
        .AUX_BASE  (AB),
        .GPIO_WAIT (GW),
        .TIMEOUT   (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_rdata      (cpu_rdata),
        .cpu_ready      (cpu_ready),
        .cpu_err        (cpu_err),
        .per_addr       (per_addr),
        .per_wdata      (per_wdata),
        .per_we         (per_we),
        .per_sel_gpio   (per_sel_gpio),
        .per_sel_aux    (per_sel_aux),
        .per_rdata_gpio (per_rdata_gpio),
        .per_rdata_aux  (per_rdata_aux),
        .per_ack_aux    (per_ack_aux)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nasrt++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Address map model: kind 0 = unmapped, 1 = GPIO, 2 = AUX.
    function automatic void model_decode(input logic [31:0] a, output int kind,
                                         output logic [31:0] off);
        longint unsigned ua = a;
        longint unsigned g  = GB;
        longint unsigned x  = AB;
        kind = 0;
        off  = 0;
        if (ua % 4 != 0) kind = 0;
        else if (ua >= g && ua < g + 8) begin kind = 1; off = 32'((ua - g) / 4); end
        else if (ua >= x && ua < x + 16) begin kind = 2; off = 32'((ua - x) / 4); end
    endfunction

    // One complete transaction; ack_at = AUX ACCESS cycle carrying the ack (0: none).
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] gdata, input logic [31:0] adata,
                           input int ack_at, input bit spurious);
        int kind, lat;
        logic [31:0] off, rdx;
        logic erx;
        bit acc;
        model_decode(addr, kind, off);
        if (kind == 0) begin lat = 2; erx = 1'b1; rdx = '0; end
        else if (kind == 1) begin lat = GW + 3; erx = 1'b0; rdx = we ? 32'h0 : gdata; end
        else if (ack_at >= 1 && ack_at <= TO) begin
            lat = ack_at + 2; erx = 1'b0; rdx = we ? 32'h0 : adata;
        end else begin lat = TO + 2; erx = 1'b1; rdx = '0; end

        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        per_rdata_gpio = gdata; per_rdata_aux = adata;
        per_ack_aux = spurious ? 1'($urandom) : 1'b0;
        for (int c = 2; c <= lat; c++) begin
            @(negedge clk);
            acc = (kind != 0) && (c < lat);
            chk("sel_gpio", 32'(per_sel_gpio), 32'(acc && kind == 1));
            chk("sel_aux", 32'(per_sel_aux), 32'(acc && kind == 2));
            chk("ready", 32'(cpu_ready), 32'(c == lat));
            if (acc) begin
                chk("per_addr", per_addr, off);
                chk("per_we", 32'(per_we), 32'(we));
                chk("per_wdata", per_wdata, wdata);
            end
            if (c == lat) begin
                chk("err", 32'(cpu_err), 32'(erx));
                if (kind != 0) chk("rdata", cpu_rdata, rdx);
            end
            // Scramble the bus: the access must run on latched values only.
            cpu_req = 1'b0; cpu_we = 1'($urandom);
            cpu_addr = $urandom; cpu_wdata = $urandom;
            if (kind == 2) per_ack_aux = (c - 1 == ack_at);
            else per_ack_aux = spurious ? 1'($urandom) : 1'b0;
        end
        @(negedge clk);
        per_ack_aux = 1'b0;
        chk("ready_after", 32'(cpu_ready), 32'h0);
        chk("sel_after", 32'({per_sel_gpio, per_sel_aux}), 32'h0);
        if (kind != 0) chk("rdata_hold", cpu_rdata, rdx);
    endtask

    initial begin
        int lat1, r;
        logic [31:0] a;
        rst = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        per_rdata_gpio = 0; per_rdata_aux = 0; per_ack_aux = 0;
        repeat (2) @(negedge clk);
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_ready", 32'(cpu_ready), 32'h0);
        chk("rst_err", 32'(cpu_err), 32'h0);
        chk("rst_per_addr", per_addr, 32'h0);
        chk("rst_per_wdata", per_wdata, 32'h0);
        chk("rst_per_we", 32'(per_we), 32'h0);
        chk("rst_sels", 32'({per_sel_gpio, per_sel_aux}), 32'h0);
        rst = 1'b0;

        // Directed cases.
        run_txn(1'b1, 32'h1001_0024, 32'h0000_00A5, 32'h0, 32'h0, 0, 1'b0);
        run_txn(1'b0, 32'h1001_0028, 32'h0, 32'h0000_003C, 32'h0, 0, 1'b0);
        run_txn(1'b0, 32'h1001_0030, 32'h0, 32'h0, 32'hDEAD_BEEF, 3, 1'b0);
        run_txn(1'b0, 32'h1001_0034, 32'h0, 32'h0, 32'h1234_5678, 0, 1'b0);
        run_txn(1'b0, 32'h1001_003C, 32'h0, 32'h0, 32'hCAFE_0001, TO, 1'b0);
        run_txn(1'b0, 32'h1001_0038, 32'h0, 32'h0, 32'hCAFE_0002, TO + 1, 1'b0);
        run_txn(1'b1, 32'h1001_0030, 32'h5555_AAAA, 32'h0, 32'hFFFF_FFFF, 1, 1'b0);
        run_txn(1'b0, 32'h0000_0000, 32'h0, 32'h0, 32'h0, 0, 1'b1);
        run_txn(1'b0, 32'h1001_0025, 32'h0, 32'h0, 32'h0, 0, 1'b1);
        run_txn(1'b0, 32'h1001_002C, 32'h0, 32'h0, 32'h0, 0, 1'b0);
        run_txn(1'b0, 32'h1001_0040, 32'h0, 32'h0, 32'h0, 0, 1'b0);
        run_txn(1'b0, 32'h1001_0020, 32'h0, 32'h0, 32'h0, 0, 1'b0);
        run_txn(1'b0, 32'h1001_002C - 32'h4, 32'h0, 32'h7777_0000, 32'h0, 0, 1'b1);

        // Back-to-back GPIO reads with the request held high.
        lat1 = GW + 3;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1001_0028; per_rdata_gpio = 32'h3C;
        for (int c = 2; c <= 2 * lat1; c++) begin
            @(negedge clk);
            chk("b2b_sel_gpio", 32'(per_sel_gpio),
                32'((c >= 2 && c < lat1) || (c >= lat1 + 2 && c < 2 * lat1)));
            chk("b2b_sel_aux", 32'(per_sel_aux), 32'h0);
            chk("b2b_ready", 32'(cpu_ready), 32'(c == lat1 || c == 2 * lat1));
            if (c == lat1) begin
                chk("b2b_rdata1", cpu_rdata, 32'h3C);
                per_rdata_gpio = 32'h5A;
            end
            if (c == 2 * lat1) chk("b2b_rdata2", cpu_rdata, 32'h5A);
            if (c == 2 * lat1 - 1) cpu_req = 1'b0;
        end
        @(negedge clk);
        chk("b2b_idle", 32'({cpu_ready, per_sel_gpio}), 32'h0);

        // Reset during a GPIO access.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h1001_0024; cpu_wdata = 32'h99;
        @(negedge clk);
        cpu_req = 1'b0;
        chk("rst_mid_sel_before", 32'(per_sel_gpio), 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_mid_sel", 32'({per_sel_gpio, per_sel_aux}), 32'h0);
        chk("rst_mid_per", per_wdata | per_addr | 32'(per_we), 32'h0);
        chk("rst_mid_rdata", cpu_rdata, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_mid_ready", 32'({cpu_ready, cpu_err}), 32'h0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", 32'({cpu_ready, per_sel_gpio, per_sel_aux}), 32'h0);
        run_txn(1'b0, 32'h1001_002C - 32'h4, 32'h0, 32'h0BAD_F00D, 32'h0, 0, 1'b0);

        // Random transactions.
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom % 4);
            case (r)
                0: a = GB + ($urandom % 12);
                1: a = AB - 32'd4 + ($urandom % 24);
                2: a = $urandom;
                default: a = GB - 32'd8 + 32'd4 * ($urandom % 12);
            endcase
            run_txn(1'($urandom), a, $urandom, $urandom, $urandom,
                    int'($urandom_range(0, TO + 2)), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
        $finish;
    end

endmodule
